// File: rtl/ifq.sv
// Instruction fetch queue: requests cache lines, buffers them, hands one instruction per cycle to dispatch.
// Latency: a line captured on edge N is dispatchable in the cycle after N; a redirect costs 2 cycles on a hit.
// Backpressure: fetch stalls (rd_en=0) while all line entries are occupied; rd_inst is ignored while empty.
module ifq #(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    CACHE_LINE_WIDTH = 128,
  parameter int                    QUEUE_DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC         = 32'h0040_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [DATA_WIDTH-1:0]       PC_in,
  output logic                        rd_en,
  output logic                        abort,
  input  logic [CACHE_LINE_WIDTH-1:0] D_out,
  input  logic                        d_out_valid,
  output logic [DATA_WIDTH-1:0]       inst,
  output logic [DATA_WIDTH-1:0]       pc_out,
  output logic                        empty,
  input  logic                        rd_inst,
  input  logic [DATA_WIDTH-1:0]       jmp_br_addr,
  input  logic                        jmp_br_valid
);

  localparam int WORDS  = CACHE_LINE_WIDTH / DATA_WIDTH;
  localparam int WORD_W = $clog2(WORDS);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OFS_W  = $clog2(CACHE_LINE_WIDTH / 8);

  localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(QUEUE_DEPTH);
  localparam logic [WORD_W-1:0]     LAST_WORD  = WORD_W'(WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] LINE_BYTES = DATA_WIDTH'(CACHE_LINE_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(DATA_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] LINE_MASK  = ~(LINE_BYTES - DATA_WIDTH'(1));
  localparam logic [DATA_WIDTH-1:0] RESET_LINE = RESET_PC & LINE_MASK;

  logic [CACHE_LINE_WIDTH-1:0] line_q [QUEUE_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [WORD_W-1:0]     rd_word_q,  rd_word_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] deq_pc_q,   deq_pc_d;

  logic                        fill, pop, retire;
  logic [CACHE_LINE_WIDTH-1:0] head_line;
  logic [DATA_WIDTH-1:0]       head_word;

  // Request/status outputs; a redirect suppresses the cache request in its own cycle.
  assign rd_en  = rst_n & (count_q != FULL_CNT) & ~jmp_br_valid;
  assign abort  = rst_n & jmp_br_valid;
  assign PC_in  = fetch_pc_q;
  assign empty  = (count_q == '0);
  assign pc_out = deq_pc_q;
  assign inst   = empty ? '0 : head_word;

  // Redirect wins over both fill and pop on the same edge.
  assign fill   = rd_en & d_out_valid;
  assign pop    = rd_inst & ~empty & ~jmp_br_valid;
  assign retire = pop & (rd_word_q == LAST_WORD);

  // Select the current instruction out of the head line.
  always_comb begin
    head_line = line_q[rd_ptr_q];
    head_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (rd_word_q == WORD_W'(k)) head_word = head_line[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state for pointers, occupancy, word index and the two PCs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_word_d  = rd_word_q;
    fetch_pc_d = fetch_pc_q;
    deq_pc_d   = deq_pc_q;
    if (jmp_br_valid) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = jmp_br_addr & LINE_MASK;
      rd_word_d  = jmp_br_addr[OFS_W-1 -: WORD_W];
      deq_pc_d   = jmp_br_addr;
    end else begin
      if (fill) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + LINE_BYTES;
      end
      if (pop) begin
        deq_pc_d  = deq_pc_q + WORD_BYTES;
        rd_word_d = rd_word_q + WORD_W'(1);
        if (retire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (fill && !retire) count_d = count_q + CNT_W'(1);
      else if (!fill && retire) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_word_q  <= '0;
      fetch_pc_q <= RESET_LINE;
      deq_pc_q   <= RESET_PC;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_word_q  <= rd_word_d;
      fetch_pc_q <= fetch_pc_d;
      deq_pc_q   <= deq_pc_d;
    end
  end

  // Line storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (fill) line_q[wr_ptr_q] <= D_out;
  end

endmodule

// File: tb/tb_ifq.sv
module tb_ifq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic         clk;
  logic         rst_n;
  logic [31:0]  PC_in;
  logic         rd_en;
  logic         abort;
  logic [127:0] D_out;
  logic         d_out_valid;
  logic [31:0]  inst;
  logic [31:0]  pc_out;
  logic         empty;
  logic         rd_inst;
  logic [31:0]  jmp_br_addr;
  logic         jmp_br_valid;

  int vecs = 0;
  int miscompares = 0;

  ifq #(
    .DATA_WIDTH(32), .CACHE_LINE_WIDTH(128), .QUEUE_DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .rd_en(rd_en), .abort(abort),
    .D_out(D_out), .d_out_valid(d_out_valid), .inst(inst), .pc_out(pc_out),
    .empty(empty), .rd_inst(rd_inst), .jmp_br_addr(jmp_br_addr), .jmp_br_valid(jmp_br_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents are a pure function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5A5A, pc[15:0] ^ 16'h00C3};
  endfunction

  function automatic logic [127:0] line_at(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = word_at(base + 32'(4 * k));
    return l;
  endfunction

  // Cache responds combinationally to whatever address the queue presents.
  always_comb D_out = line_at(PC_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rd_en"},  32'(rd_en), 32'd0);
    chk({tag, " abort"},  32'(abort), 32'd0);
    chk({tag, " empty"},  32'(empty), 32'd1);
    chk({tag, " inst"},   inst,       32'd0);
    chk({tag, " pc_out"}, pc_out,     RESET_PC);
    chk({tag, " PC_in"},  PC_in,      RESET_PC);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd_inst = 1'b0; d_out_valid = 1'b0; jmp_br_valid = 1'b0; jmp_br_addr = '0;
    @(posedge clk); #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic        dv;
    logic        jv;
    logic [31:0] ja;
    logic        e_rden;
    logic        e_abort;
    logic [31:0] e_pcin;
    logic        e_empty;
    logic [31:0] e_pcout;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic dv, input logic jv, input logic [31:0] ja,
                              input logic e_rden, input logic e_abort, input logic [31:0] e_pcin,
                              input logic e_empty, input logic [31:0] e_pcout, input logic [31:0] e_inst);
    vec_t v;
    v.rd = rd; v.dv = dv; v.jv = jv; v.ja = ja;
    v.e_rden = e_rden; v.e_abort = e_abort; v.e_pcin = e_pcin;
    v.e_empty = e_empty; v.e_pcout = e_pcout; v.e_inst = e_inst;
    return v;
  endfunction

  // Behavioural reference: queue of buffered line addresses plus dispatch position.
  logic [31:0] m_lines[$];
  int          m_head;
  logic [31:0] m_fetch;
  logic [31:0] m_next;

  task automatic model_reset();
    m_lines.delete();
    m_head  = 0;
    m_fetch = RESET_PC & ~32'hF;
    m_next  = RESET_PC;
  endtask

  task automatic model_edge(input logic rd, input logic dv, input logic jv, input logic [31:0] ja);
    logic can_fetch;
    can_fetch = (m_lines.size() < DEPTH) && !jv;
    if (jv) begin
      m_lines.delete();
      m_fetch = ja & ~32'hF;
      m_head  = int'(ja[3:2]);
      m_next  = ja;
    end else begin
      if (rd && m_lines.size() > 0) begin
        m_next = m_next + 32'd4;
        if (m_head == 3) begin
          m_head = 0;
          void'(m_lines.pop_front());
        end else begin
          m_head++;
        end
      end
      if (can_fetch && dv) begin
        m_lines.push_back(m_fetch);
        m_fetch = m_fetch + 32'd16;
      end
    end
  endtask

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv, pr, pj;
    int seg_p[6][3];
    logic [31:0] w0, w10, w4f8;
    logic        ev;

    w0   = word_at(32'h0040_0000);
    w10  = word_at(32'h0040_0010);
    w4f8 = word_at(32'h0040_00F8);
    //            rd dv jv addr            rden abrt PC_in          empty pc_out          inst
    tbl[0]  = mk(0, 0, 0, 32'h0,          1,   0,   32'h0040_0000, 1,    32'h0040_0000,  32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,          1,   0,   32'h0040_0000, 1,    32'h0040_0000,  32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,          1,   0,   32'h0040_0000, 1,    32'h0040_0000,  32'h0);
    tbl[3]  = mk(0, 1, 0, 32'h0,          1,   0,   32'h0040_0000, 1,    32'h0040_0000,  32'h0);
    tbl[4]  = mk(0, 1, 0, 32'h0,          1,   0,   32'h0040_0010, 0,    32'h0040_0000,  w0);
    tbl[5]  = mk(0, 1, 0, 32'h0,          1,   0,   32'h0040_0020, 0,    32'h0040_0000,  w0);
    tbl[6]  = mk(0, 1, 0, 32'h0,          1,   0,   32'h0040_0030, 0,    32'h0040_0000,  w0);
    tbl[7]  = mk(1, 1, 0, 32'h0,          0,   0,   32'h0040_0040, 0,    32'h0040_0000,  w0);
    tbl[8]  = mk(1, 1, 0, 32'h0,          0,   0,   32'h0040_0040, 0,    32'h0040_0004,  word_at(32'h0040_0004));
    tbl[9]  = mk(1, 1, 0, 32'h0,          0,   0,   32'h0040_0040, 0,    32'h0040_0008,  word_at(32'h0040_0008));
    tbl[10] = mk(1, 1, 0, 32'h0,          0,   0,   32'h0040_0040, 0,    32'h0040_000C,  word_at(32'h0040_000C));
    tbl[11] = mk(0, 1, 0, 32'h0,          1,   0,   32'h0040_0040, 0,    32'h0040_0010,  w10);
    tbl[12] = mk(1, 1, 1, 32'h0040_00F8,  0,   1,   32'h0040_0050, 0,    32'h0040_0010,  w10);
    tbl[13] = mk(0, 0, 0, 32'h0,          1,   0,   32'h0040_00F0, 1,    32'h0040_00F8,  32'h0);
    tbl[14] = mk(1, 1, 0, 32'h0,          1,   0,   32'h0040_00F0, 1,    32'h0040_00F8,  32'h0);
    tbl[15] = mk(0, 0, 0, 32'h0,          1,   0,   32'h0040_0100, 0,    32'h0040_00F8,  w4f8);

    // Directed table: reset, retry on miss, fill to full, drain, retire, redirect.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rd_inst = tbl[i].rd; d_out_valid = tbl[i].dv;
      jmp_br_valid = tbl[i].jv; jmp_br_addr = tbl[i].ja;
      #1;
      chk($sformatf("row%0d rd_en", i),  32'(rd_en), 32'(tbl[i].e_rden));
      chk($sformatf("row%0d abort", i),  32'(abort), 32'(tbl[i].e_abort));
      chk($sformatf("row%0d PC_in", i),  PC_in,      tbl[i].e_pcin);
      chk($sformatf("row%0d empty", i),  32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("row%0d pc_out", i), pc_out,     tbl[i].e_pcout);
      chk($sformatf("row%0d inst", i),   inst,       tbl[i].e_inst);
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle with three lines buffered.
    do_reset();
    d_out_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-async empty", 32'(empty), 32'd0);
    chk("pre-async pc_out", pc_out, RESET_PC);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");

    // Randomized segments against the reference model; segment 1 is steady-state streaming.
    seg_p = '{'{100, 0, 0}, '{100, 100, 0}, '{70, 60, 5}, '{50, 90, 10}, '{100, 100, 3}, '{30, 30, 2}};
    do_reset();
    model_reset();
    for (int s = 0; s < 6; s++) begin
      pv = seg_p[s][0]; pr = seg_p[s][1]; pj = seg_p[s][2];
      for (int n = 0; n < 100; n++) begin
        rd_inst      = ($urandom_range(99) < pr);
        d_out_valid  = ($urandom_range(99) < pv);
        jmp_br_valid = ($urandom_range(99) < pj);
        jmp_br_addr  = 32'h0040_0000 + (32'($urandom_range(1023)) << 2);
        #1;
        ev = (m_lines.size() == 0);
        chk("rnd rd_en", 32'(rd_en), 32'((m_lines.size() < DEPTH) && !jmp_br_valid));
        chk("rnd abort", 32'(abort), 32'(jmp_br_valid));
        chk("rnd PC_in", PC_in, m_fetch);
        chk("rnd empty", 32'(empty), 32'(ev));
        chk("rnd pc_out", pc_out, m_next);
        chk("rnd inst", inst, ev ? 32'h0 : word_at(m_lines[0] + 32'(4 * m_head)));
        @(posedge clk);
        model_edge(rd_inst, d_out_valid, jmp_br_valid, jmp_br_addr);
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/ifq.md
# ifq

Instruction fetch queue sitting between `i_cache` and the dispatch stage. It drives the cache's `PC_in`/`rd_en`/`abort` request port, captures each returned 128-bit cache line into a line-buffer FIFO, and presents one 32-bit instruction per cycle with its PC to dispatch. Taken branches and jumps redirect the fetch PC and flush the queue.

## Interface

Parameters:

- `DATA_WIDTH`, 32, instruction and PC width.
- `CACHE_LINE_WIDTH`, 128, cache line width (4 instructions).
- `QUEUE_DEPTH`, 4, number of line entries (power of 2).
- `RESET_PC`, 32'h0040_0000, first fetch/dispatch PC after reset.

Ports:

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `PC_in` out 32: fetch address to cache; equals `fetch_pc`.
- `rd_en` out 1: cache read request.
- `abort` out 1: cancels the current cache access.
- `D_out` in 128: line returned by cache; word k at bits [32k+31:32k].
- `d_out_valid` in 1: `D_out` valid this cycle (combinational cache response).
- `inst` out 32: instruction at queue head; 0 when `empty`.
- `pc_out` out 32: PC of `inst`.
- `empty` out 1: no instruction available.
- `rd_inst` in 1: dispatch consumes head instruction this cycle.
- `jmp_br_addr` in 32: redirect target, word-aligned.
- `jmp_br_valid` in 1: redirect strobe, one cycle.

## Operation

- State:
  - `line_q[QUEUE_DEPTH]` of 128 bits.
  - `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, 0..DEPTH.
  - `rd_word`, 2 bits, word index within the head line.
  - `fetch_pc`, always line-aligned (bits [3:0]=0).
  - `deq_pc`, 32 bits.
- Combinational outputs:
  - `rd_en = rst_n & (count != DEPTH) & ~jmp_br_valid`.
  - `abort = jmp_br_valid`.
  - `PC_in = fetch_pc`.
  - `empty = (count == 0)`.
  - `inst = empty ? 0 : line_q[rd_ptr][32*rd_word +: 32]`.
  - `pc_out = deq_pc`.
- Fill: on an edge with `rd_en & d_out_valid`:
  - `line_q[wr_ptr] <= D_out`.
  - `wr_ptr++`.
  - `fetch_pc <= fetch_pc + 16`.
- `d_out_valid=0` with `rd_en=1`: nothing written; the same `fetch_pc` is retried the next cycle.
- Pop: on an edge with `rd_inst & ~empty`:
  - `deq_pc <= deq_pc + 4`.
  - If `rd_word == 3`: `rd_word <= 0`, `rd_ptr++`, line retired. Otherwise `rd_word++`.
- `rd_inst` while `empty`: ignored, no state change.
- `count` update: +1 on fill only, -1 on line retire only. Fill and retire in the same edge leave it unchanged.
- Full (`count == DEPTH`): `rd_en=0` and fetch stalls. A retire on that edge re-enables fetch the next cycle; there is no same-cycle bypass.
- Redirect, on an edge with `jmp_br_valid`. It has priority over fill and pop; neither happens on that edge.
  - `wr_ptr`, `rd_ptr`, `count` <= 0.
  - `fetch_pc <= {jmp_br_addr[31:4], 4'b0}`.
  - `rd_word <= jmp_br_addr[3:2]`.
  - `deq_pc <= jmp_br_addr`.
- Words preceding the target in the first fetched line are skipped via `rd_word`.
- Wrap-around: pointers wrap silently. `count` is the sole full/empty discriminator.

## Timing

- Reset (async assert, any time, including mid-fill or mid-redirect):
  - Pointers, `count`, `rd_word` = 0.
  - `fetch_pc` = `RESET_PC` line-aligned; `deq_pc` = `RESET_PC`.
  - Outputs: `rd_en=0`, `abort=0`, `empty=1`, `inst=0`, `pc_out=RESET_PC`, `PC_in=RESET_PC`.
- Release: `rd_en=1` in the first cycle after `rst_n` rises. The first line is captured on the first edge with `d_out_valid=1`.
- Fill-to-dispatch latency: 1 edge. The line captured at edge N makes `empty=0` and `inst` valid in the cycle after N.
- Throughput: 1 line/cycle fill, 1 instruction/cycle dispatch. Steady state keeps the queue full.
- Redirect: `abort=1` and `rd_en=0` during the `jmp_br_valid` cycle.
  - The next cycle: `empty=1`, `PC_in` = target line, `rd_en=1`.
  - The first target instruction is visible 2 cycles after the `jmp_br_valid` cycle, assuming a cache hit.

## Test plan

- Reset then fetch, `d_out_valid=1`, `rd_inst=0`:
  - `PC_in` steps 0x400000, 0x400010, 0x400020, 0x400030.
  - After 4 fills `rd_en=0`, `count=4`.
  - `inst` = word 0 of the line at 0x400000; `pc_out=0x400000`.
- Full queue, `rd_inst=1` for 4 cycles:
  - `pc_out` goes 0x400000→0x400004→0x400008→0x40000C.
  - On the 4th edge `rd_ptr=1`; the next cycle `rd_en=1` and `PC_in=0x400040`.
- Steady state, `rd_inst=1` continuously:
  - 16+ instructions dispatched with consecutive PCs.
  - Pointers wrap 3→0 with no gap or duplicate.
- `jmp_br_valid=1`, `jmp_br_addr=0x4000F8`, in the same cycle as `rd_inst=1` and a fill:
  - `abort=1` that cycle.
  - Next cycle `empty=1`, `PC_in=0x4000F0`.
  - After one fill: `pc_out=0x4000F8` and `inst` = word 2 of that line.
- `d_out_valid=0` for 3 cycles after reset:
  - `PC_in` held at 0x400000 and `empty` stays 1.
  - On the first valid edge the line is captured.
- Assert `rst_n=0` asynchronously mid-cycle with `count=3`:
  - All outputs immediately take their reset values, with no clock edge required.
